// File: rtl/psychic5_romreq_pkg.sv
// psychic5_romreq_pkg: shared FSM states and grant helpers for the ROM request arbiter.
package psychic5_romreq_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    function automatic int chw(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

    // First requesting index at or after start, wrapping modulo n (n <= 8).
    function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] start, input int n);
        logic [2:0] idx;
        logic found;
        rr_pick = start;
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            idx = 3'((int'(start) + k) % n);
            if (k < n && !found && req[idx]) begin
                rr_pick = idx;
                found = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/psychic5_romreq_latch.sv
// psychic5_romreq_latch: one-entry tagged data latch with hit compare for a single channel.
module psychic5_romreq_latch #(
    parameter int AW = 17,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          wr,
    input  logic [AW-1:0] wr_tag,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] addr,
    output logic          hit,
    output logic [DW-1:0] data
);
    logic          valid_q, valid_d;
    logic [AW-1:0] tag_q, tag_d;
    logic [DW-1:0] data_q, data_d;

    // A completing write beats a coincident flush.
    always_comb begin
        valid_d = wr ? 1'b1 : flush ? 1'b0 : valid_q;
        tag_d   = wr ? wr_tag : tag_q;
        data_d  = wr ? wr_data : data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

    assign hit  = valid_q && tag_q == addr;
    assign data = data_q;
endmodule

// File: rtl/psychic5_romreq_arbiter.sv
// psychic5_romreq_arbiter: shares one SDRAM read port among CH channels, each with a tagged data latch.
module psychic5_romreq_arbiter
    import psychic5_romreq_pkg::*;
#(
    parameter int                 CH      = 2,
    parameter int                 AW      = 17,
    parameter int                 DW      = 8,
    parameter int                 SAW     = 22,
    parameter logic [CH*SAW-1:0]  CH_BASE = '0,
    parameter bit                 RR_MODE = 1'b1
) (
    input  logic             i_EMU_MCLK,
    input  logic             i_EMU_INITRST_n,
    input  logic             i_FLUSH,
    input  logic [CH-1:0]    i_CH_RQ_n,
    input  logic [CH*AW-1:0] i_CH_ADDR,
    output logic [CH*DW-1:0] o_CH_DATA,
    output logic [CH-1:0]    o_CH_RDY,
    output logic             o_SDRAM_RQ,
    output logic [SAW-1:0]   o_SDRAM_ADDR,
    input  logic             i_SDRAM_ACK,
    input  logic             i_SDRAM_DVALID,
    input  logic [DW-1:0]    i_SDRAM_DATA,
    output logic             o_BUSY
);
    localparam int CW = chw(CH);

    state_t         state_q, state_d;
    logic [CW-1:0]  gch_q, gch_d, last_q, last_d, pick_c;
    logic [AW-1:0]  gaddr_q, gaddr_d;
    logic           rq_q, rq_d;
    logic [SAW-1:0] saddr_q, saddr_d;
    logic [CH-1:0]  hit, pend, wr;
    logic [AW-1:0]  addr_a [CH];
    logic [2:0]     start, pick;
    logic           done;

    assign done = (state_q == ISSUE && i_SDRAM_ACK && i_SDRAM_DVALID) || (state_q == WAIT && i_SDRAM_DVALID);

    for (genvar i = 0; i < CH; i++) begin : g_ch
        assign addr_a[i]   = i_CH_ADDR[i*AW +: AW];
        assign wr[i]       = done && gch_q == CW'(i);
        assign o_CH_RDY[i] = ~i_CH_RQ_n[i] && hit[i];
        assign pend[i]     = ~i_CH_RQ_n[i] && ~hit[i] && ~(state_q != IDLE && gch_q == CW'(i) && gaddr_q == addr_a[i]);
        psychic5_romreq_latch #(.AW(AW), .DW(DW)) u_latch (
            .clk     (i_EMU_MCLK),
            .rst_n   (i_EMU_INITRST_n),
            .flush   (i_FLUSH),
            .wr      (wr[i]),
            .wr_tag  (gaddr_q),
            .wr_data (i_SDRAM_DATA),
            .addr    (addr_a[i]),
            .hit     (hit[i]),
            .data    (o_CH_DATA[i*DW +: DW])
        );
    end

    assign start  = RR_MODE ? 3'((int'(last_q) + 1) % CH) : 3'd0;
    assign pick   = rr_pick(8'(pend), start, CH);
    assign pick_c = CW'(pick);

    always_comb begin
        state_d = state_q;
        gch_d   = gch_q;
        last_d  = last_q;
        gaddr_d = gaddr_q;
        rq_d    = rq_q;
        saddr_d = saddr_q;
        if (state_q == IDLE && |pend) begin
            gch_d   = pick_c;
            last_d  = pick_c;
            gaddr_d = addr_a[pick_c];
            saddr_d = CH_BASE[pick_c*SAW +: SAW] + SAW'(addr_a[pick_c]);
            rq_d    = 1'b1;
            state_d = ISSUE;
        end else if (state_q == ISSUE && i_SDRAM_ACK) begin
            rq_d    = 1'b0;
            state_d = i_SDRAM_DVALID ? IDLE : WAIT;
        end else if (state_q == WAIT && i_SDRAM_DVALID) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge i_EMU_MCLK or negedge i_EMU_INITRST_n) begin
        if (!i_EMU_INITRST_n) begin
            state_q <= IDLE;
            gch_q   <= '0;
            last_q  <= '0;
            gaddr_q <= '0;
            rq_q    <= 1'b0;
            saddr_q <= '0;
        end else begin
            state_q <= state_d;
            gch_q   <= gch_d;
            last_q  <= last_d;
            gaddr_q <= gaddr_d;
            rq_q    <= rq_d;
            saddr_q <= saddr_d;
        end
    end

    assign o_SDRAM_RQ   = rq_q;
    assign o_SDRAM_ADDR = saddr_q;
    assign o_BUSY       = state_q != IDLE;
endmodule

// File: tb/tb_psychic5_romreq_arbiter.sv
// tb_psychic5_romreq_arbiter: two arbiters (round-robin and fixed priority) checked against a fetch-level model.
module tb_psychic5_romreq_arbiter;
    localparam logic [65:0] CB = {22'h3FFFFF, 22'h100000, 22'h000000};
    localparam logic [21:0] BASE [3] = '{22'h000000, 22'h100000, 22'h3FFFFF};

    logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
    logic [2:0]  rq_n = 3'b111;
    logic [16:0] a [3] = '{17'h0, 17'h0, 17'h0};
    logic [50:0] ch_addr;
    logic [1:0]  ack = 2'b00, dv = 2'b00;
    logic [7:0]  sdata = 8'h00;
    logic [23:0] dat [2];
    logic [2:0]  rdy [2];
    logic        rq [2], busy [2];
    logic [21:0] saddr [2];
    logic [16:0] pool [4] = '{17'h00123, 17'h00124, 17'h1FFFF, 17'h00001};

    int vecs = 0, miss = 0;

    // Model: per-channel latch contents plus the single outstanding fetch (active, accepted, channel, address).
    logic        mv [2][3];
    logic [16:0] mt [2][3];
    logic [7:0]  md [2][3];
    logic        fa [2], fk [2];
    int          fc [2], lg [2];
    logic [16:0] fad [2];
    logic [21:0] msa [2];

    assign ch_addr = {a[2], a[1], a[0]};
    always #5 clk = ~clk;

    for (genvar d = 0; d < 2; d++) begin : g_dut
        psychic5_romreq_arbiter #(.CH(3), .AW(17), .DW(8), .SAW(22), .CH_BASE(CB), .RR_MODE(d == 0)) dut (
            .i_EMU_MCLK      (clk),
            .i_EMU_INITRST_n (rst_n),
            .i_FLUSH         (flush),
            .i_CH_RQ_n       (rq_n),
            .i_CH_ADDR       (ch_addr),
            .o_CH_DATA       (dat[d]),
            .o_CH_RDY        (rdy[d]),
            .o_SDRAM_RQ      (rq[d]),
            .o_SDRAM_ADDR    (saddr[d]),
            .i_SDRAM_ACK     (ack[d]),
            .i_SDRAM_DVALID  (dv[d]),
            .i_SDRAM_DATA    (sdata),
            .o_BUSY          (busy[d])
        );
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit held(int d, int c);
        return mv[d][c] && mt[d][c] == a[c];
    endfunction

    function automatic int pick(int d);
        for (int k = 1; k <= 3; k++) begin
            int c = d == 0 ? (lg[d] + k) % 3 : k - 1;
            if (!rq_n[c] && !held(d, c)) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 3; c++) begin
                mv[d][c] = 1'b0;
                mt[d][c] = '0;
                md[d][c] = '0;
            end
            fa[d] = 1'b0; fk[d] = 1'b0; fc[d] = 0; lg[d] = 0; fad[d] = '0; msa[d] = '0;
        end
    endtask

    task automatic model_step(int d);
        bit done;
        int g;
        g = fa[d] ? -1 : pick(d);
        done = fa[d] && dv[d] && (fk[d] || ack[d]);
        if (flush) for (int c = 0; c < 3; c++) mv[d][c] = 1'b0;
        if (done) begin
            mv[d][fc[d]] = 1'b1;
            mt[d][fc[d]] = fad[d];
            md[d][fc[d]] = sdata;
            fa[d] = 1'b0;
        end else if (fa[d]) begin
            if (ack[d]) fk[d] = 1'b1;
        end else if (g >= 0) begin
            fa[d] = 1'b1; fk[d] = 1'b0; fc[d] = g; fad[d] = a[g]; lg[d] = g;
            msa[d] = BASE[g] + 22'(a[g]);
        end
    endtask

    task automatic compare();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d sdram_rq", d), rq[d], fa[d] && !fk[d]);
            chk($sformatf("d%0d busy", d), busy[d], fa[d]);
            chk($sformatf("d%0d sdram_addr", d), saddr[d], msa[d]);
            for (int c = 0; c < 3; c++) begin
                chk($sformatf("d%0d rdy%0d", d, c), rdy[d][c], !rq_n[c] && held(d, c));
                chk($sformatf("d%0d data%0d", d, c), dat[d][c*8 +: 8], md[d][c]);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare();
        if (rst_n) for (int d = 0; d < 2; d++) model_step(d);
        @(posedge clk);
        #1;
    endtask

    task automatic respond(input bit rnd);
        for (int d = 0; d < 2; d++) begin
            ack[d] = fa[d] && !fk[d] && (!rnd || ($urandom % 2) == 1);
            dv[d]  = rnd ? ($urandom % 3) == 0 : fk[d];
        end
        sdata = 8'($urandom);
    endtask

    task automatic drain();
        rq_n = 3'b111;
        for (int i = 0; i < 12; i++) begin
            respond(1'b0);
            tick();
        end
        ack = 2'b00; dv = 2'b00;
        chk("drain idle", {busy[1], busy[0]}, 0);
    endtask

    initial begin
        bit ch, lastch, prq [2];
        int ng;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("reset rq", rq[0], 0);
        chk("reset busy", busy[0], 0);
        chk("reset addr", saddr[0], 0);

        // First miss, fetch and hit.
        rq_n = 3'b110; a[0] = 17'h00123;
        #1 chk("miss rdy0", rdy[0][0], 0);
        tick();
        chk("miss rq", rq[0], 1);
        chk("miss addr", saddr[0], 22'h000123);
        chk("miss addr fixed", saddr[1], 22'h000123);
        ack = 2'b11; tick(); ack = 2'b00;
        chk("ack drops rq", rq[0], 0);
        dv = 2'b11; sdata = 8'hA5; tick(); dv = 2'b00;
        chk("fill rdy0", rdy[0][0], 1);
        chk("fill data0", dat[0][7:0], 8'hA5);
        tick();
        chk("hit no rq", rq[0], 0);
        a[0] = 17'h00124;
        #1 chk("new addr rdy0", rdy[0][0], 0);
        tick();
        chk("refetch addr", saddr[0], 22'h000124);
        ack = 2'b11; tick(); ack = 2'b00;
        dv = 2'b11; sdata = 8'h5A; tick(); dv = 2'b00;

        // Base offset and wrap.
        rq_n = 3'b101; a[1] = 17'h1FFFF;
        tick();
        chk("base addr", saddr[0], 22'h11FFFF);
        ack = 2'b11; tick(); ack = 2'b00;
        dv = 2'b11; sdata = 8'h11; tick(); dv = 2'b00;
        rq_n = 3'b011; a[2] = 17'h00001;
        tick();
        chk("wrap addr", saddr[0], 22'h000000);
        ack = 2'b11; dv = 2'b11; sdata = 8'hC3; tick(); ack = 2'b00; dv = 2'b00;
        chk("ack+dv idle", busy[0], 0);
        chk("ack+dv rdy2", rdy[0][2], 1);
        chk("ack+dv data2", dat[0][23:16], 8'hC3);

        // Continuous misses on ch0 and ch1.
        rq_n = 3'b100; ng = 0; lastch = 1'b0;
        prq[0] = rq[0]; prq[1] = rq[1];
        for (int i = 0; i < 40; i++) begin
            a[0] = 17'h100 + 17'(i); a[1] = 17'h200 + 17'(i);
            respond(1'b0);
            tick();
            for (int d = 0; d < 2; d++) begin
                if (rq[d] && !prq[d]) begin
                    ch = saddr[d] >= 22'h100000;
                    if (d == 0) begin
                        if (ng > 0) chk("rr alternates", ch, !lastch);
                        lastch = ch;
                        ng++;
                    end else chk("fixed picks ch0", ch, 0);
                end
                prq[d] = rq[d];
            end
        end
        chk("rr grant count", ng >= 4, 1);
        drain();

        // Address change while waiting for data.
        rq_n = 3'b110; a[0] = 17'h00040;
        tick();
        ack = 2'b11; tick(); ack = 2'b00;
        a[0] = 17'h00041;
        dv = 2'b11; sdata = 8'h77; tick(); dv = 2'b00;
        chk("stale rdy0", rdy[0][0], 0);
        tick();
        chk("second fetch rq", rq[0], 1);
        chk("second fetch addr", saddr[0], 22'h000041);
        a[0] = 17'h00040;
        #1 chk("old tag rdy0", rdy[0][0], 1);
        chk("old tag data0", dat[0][7:0], 8'h77);
        a[0] = 17'h00041;
        ack = 2'b11; tick(); ack = 2'b00;
        dv = 2'b11; sdata = 8'h99; tick(); dv = 2'b00;

        // Flush coincident with the fill.
        rq_n = 3'b010; a[2] = 17'h00007;
        tick();
        ack = 2'b11; tick(); ack = 2'b00;
        dv = 2'b11; flush = 1'b1; sdata = 8'h33; tick(); dv = 2'b00; flush = 1'b0;
        chk("flush keeps written", rdy[0][2], 1);
        chk("flush clears other", rdy[0][0], 0);
        chk("flush data2", dat[0][23:16], 8'h33);
        drain();

        // Reset while waiting for data.
        rq_n = 3'b110; a[0] = 17'h00060;
        tick();
        ack = 2'b11; tick(); ack = 2'b00;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst rq", rq[0], 0);
        chk("rst busy", busy[0], 0);
        chk("rst rdy", rdy[0], 0);
        tick();
        rst_n = 1'b1;
        dv = 2'b11; sdata = 8'hEE; tick(); dv = 2'b00;
        chk("late dv rdy0", rdy[0][0], 0);
        chk("late dv data0", dat[0][7:0], 8'h00);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            for (int c = 0; c < 3; c++) begin
                if ($urandom % 6 == 0) rq_n[c] = ~rq_n[c];
                if ($urandom % 8 == 0) a[c] = pool[$urandom % 4];
            end
            flush = ($urandom % 25) == 0;
            respond(1'b1);
            if ($urandom % 500 == 0) begin
                rst_n = 1'b0;
                model_reset();
            end
            tick();
            rst_n = 1'b1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule
